// File: rtl/mmio_pkg.sv
// Shared definitions for the memory-mapped I/O bridge: state encoding,
// default peripheral windows and the value returned on a read miss.
package mmio_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RD_DONE   = 2'd1,
    WR_COMMIT = 2'd2
  } bridge_state_e;

  localparam logic [31:0] DEV0_BASE_DEFAULT = 32'h0000_7f00;
  localparam logic [31:0] DEV0_TOP_DEFAULT  = 32'h0000_7f0b;
  localparam logic [31:0] DEV1_BASE_DEFAULT = 32'h0000_7f38;
  localparam logic [31:0] DEV1_TOP_DEFAULT  = 32'h0000_7f3f;

  localparam logic [31:0] MISS_RD = 32'h0000_0000;

endpackage

// File: rtl/be_merge.sv
// Byte-lane merge: lanes enabled in be take new_data, the rest keep old_data.
// Also used by the data-memory store path.
module be_merge (
  input  logic [31:0] old_data,
  input  logic [31:0] new_data,
  input  logic [3:0]  be,
  output logic [31:0] merged
);

  always_comb begin
    merged = old_data;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) begin
        merged[8*i +: 8] = new_data[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/periph_bridge.sv
// CPU-to-peripheral bridge: decodes two address windows, passes full-word
// stores through, turns partial stores into read-modify-write, registers loads.
module periph_bridge
  import mmio_pkg::*;
#(
  parameter logic [31:0] DEV0_BASE = DEV0_BASE_DEFAULT,
  parameter logic [31:0] DEV0_TOP  = DEV0_TOP_DEFAULT,
  parameter logic [31:0] DEV1_BASE = DEV1_BASE_DEFAULT,
  parameter logic [31:0] DEV1_TOP  = DEV1_TOP_DEFAULT
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wd,
  input  logic [3:0]  cpu_be,
  input  logic        cpu_we,
  input  logic        cpu_re,
  output logic [31:0] cpu_rd,
  output logic        stall,
  output logic [31:0] t_addr,
  output logic [31:0] t_wd,
  output logic        dev0_we,
  output logic        dev1_we,
  input  logic [31:0] dev0_rd,
  input  logic [31:0] dev1_rd
);

  bridge_state_e state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic          sel_q, sel_d;
  logic [31:0]   merge_q, merge_d;
  logic [31:0]   rd_buf_q, rd_buf_d;

  logic          hit0, hit1, hit;
  logic [31:0]   dev_rd;
  logic [31:0]   word_addr;
  logic [31:0]   merged;

  assign hit0      = (cpu_addr >= DEV0_BASE) && (cpu_addr <= DEV0_TOP);
  assign hit1      = (cpu_addr >= DEV1_BASE) && (cpu_addr <= DEV1_TOP);
  assign hit       = hit0 | hit1;
  assign dev_rd    = hit0 ? dev0_rd : (hit1 ? dev1_rd : MISS_RD);
  assign word_addr = {cpu_addr[31:2], 2'b00};

  be_merge u_be_merge (
    .old_data (dev_rd),
    .new_data (cpu_wd),
    .be       (cpu_be),
    .merged   (merged)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      sel_q    <= 1'b0;
      merge_q  <= '0;
      rd_buf_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      sel_q    <= sel_d;
      merge_q  <= merge_d;
      rd_buf_q <= rd_buf_d;
    end
  end

  // sel_q remembers which device the pending partial write targets (1 = dev1).
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    sel_d    = sel_q;
    merge_d  = merge_q;
    rd_buf_d = rd_buf_q;
    stall    = 1'b0;
    dev0_we  = 1'b0;
    dev1_we  = 1'b0;
    cpu_rd   = MISS_RD;
    t_addr   = word_addr;
    t_wd     = cpu_wd;

    case (state_q)
      IDLE: begin
        if (cpu_we && hit && (cpu_be != 4'h0)) begin
          if (cpu_be == 4'hf) begin
            dev0_we = hit0;
            dev1_we = hit1 & ~hit0;
          end else begin
            stall   = 1'b1;
            addr_d  = word_addr;
            sel_d   = ~hit0;
            merge_d = merged;
            state_d = WR_COMMIT;
          end
        end else if (cpu_re && hit && !cpu_we) begin
          stall    = 1'b1;
          rd_buf_d = dev_rd;
          state_d  = RD_DONE;
        end
      end
      RD_DONE: begin
        cpu_rd  = rd_buf_q;
        state_d = IDLE;
      end
      WR_COMMIT: begin
        t_addr  = addr_q;
        t_wd    = merge_q;
        dev0_we = ~sel_q;
        dev1_we = sel_q;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Reset is asynchronous, so the outputs must go quiet as soon as clr rises.
    if (clr) begin
      stall   = 1'b0;
      dev0_we = 1'b0;
      dev1_we = 1'b0;
      cpu_rd  = '0;
      t_addr  = '0;
      t_wd    = '0;
    end
  end

endmodule

// File: tb/tb_periph_bridge.sv
// Directed testbench for periph_bridge: one task per scenario, each with
// hand-computed expectations checked a little after the driving clock edge.
module tb_periph_bridge;

  logic        clk;
  logic        clr;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wd;
  logic [3:0]  cpu_be;
  logic        cpu_we;
  logic        cpu_re;
  logic [31:0] cpu_rd;
  logic        stall;
  logic [31:0] t_addr;
  logic [31:0] t_wd;
  logic        dev0_we;
  logic        dev1_we;
  logic [31:0] dev0_rd;
  logic [31:0] dev1_rd;

  int checks = 0;
  int passed = 0;
  int dev0_strobes = 0;
  int dev1_strobes = 0;

  periph_bridge dut (
    .clk      (clk),
    .clr      (clr),
    .cpu_addr (cpu_addr),
    .cpu_wd   (cpu_wd),
    .cpu_be   (cpu_be),
    .cpu_we   (cpu_we),
    .cpu_re   (cpu_re),
    .cpu_rd   (cpu_rd),
    .stall    (stall),
    .t_addr   (t_addr),
    .t_wd     (t_wd),
    .dev0_we  (dev0_we),
    .dev1_we  (dev1_we),
    .dev0_rd  (dev0_rd),
    .dev1_rd  (dev1_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobes sampled at the capturing edge, i.e. writes that actually land.
  always @(posedge clk) begin
    if (dev0_we) dev0_strobes <= dev0_strobes + 1;
    if (dev1_we) dev1_strobes <= dev1_strobes + 1;
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_addr = 32'h0;
    cpu_wd   = 32'h0;
    cpu_be   = 4'h0;
    cpu_we   = 1'b0;
    cpu_re   = 1'b0;
  endtask

  task automatic test_reset();
    clr      = 1'b1;
    dev0_rd  = 32'h0;
    dev1_rd  = 32'h0;
    cpu_addr = 32'h7f38;
    cpu_wd   = 32'hcafe_f00d;
    cpu_be   = 4'hf;
    cpu_we   = 1'b1;
    cpu_re   = 1'b0;
    #3;
    checks++;
    if (stall !== 1'b0) $display("[TB] FAIL reset_stall got %b want 0", stall);
    else passed++;
    checks++;
    if (dev1_we !== 1'b0 || dev0_we !== 1'b0)
      $display("[TB] FAIL reset_we got %b%b want 00", dev0_we, dev1_we);
    else passed++;
    checks++;
    if (t_addr !== 32'h0 || t_wd !== 32'h0)
      $display("[TB] FAIL reset_bus got addr %h wd %h want 0 0", t_addr, t_wd);
    else passed++;
    checks++;
    if (cpu_rd !== 32'h0) $display("[TB] FAIL reset_rd got %h want 0", cpu_rd);
    else passed++;
    next_cycle();
    clr = 1'b0;
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_full_store();
    int s1;
    s1 = dev1_strobes;
    cpu_addr = 32'h7f38;
    cpu_wd   = 32'h1234_5678;
    cpu_be   = 4'hf;
    cpu_we   = 1'b1;
    #1;
    checks++;
    if (dev1_we !== 1'b1 || dev0_we !== 1'b0)
      $display("[TB] FAIL full_we got %b%b want 01", dev0_we, dev1_we);
    else passed++;
    checks++;
    if (t_addr !== 32'h7f38) $display("[TB] FAIL full_addr got %h want 00007f38", t_addr);
    else passed++;
    checks++;
    if (t_wd !== 32'h1234_5678) $display("[TB] FAIL full_wd got %h want 12345678", t_wd);
    else passed++;
    checks++;
    if (stall !== 1'b0) $display("[TB] FAIL full_stall got %b want 0", stall);
    else passed++;
    next_cycle();
    idle_inputs();
    #1;
    checks++;
    if (dev1_strobes != s1 + 1)
      $display("[TB] FAIL full_count got %0d want %0d", dev1_strobes, s1 + 1);
    else passed++;
    next_cycle();
  endtask

  task automatic test_byte_rmw();
    cpu_addr = 32'h7f39;
    cpu_wd   = 32'h0000_ab00;
    cpu_be   = 4'b0010;
    cpu_we   = 1'b1;
    dev1_rd  = 32'h1234_5678;
    #1;
    checks++;
    if (stall !== 1'b1) $display("[TB] FAIL rmw_c0_stall got %b want 1", stall);
    else passed++;
    checks++;
    if (dev1_we !== 1'b0 || dev0_we !== 1'b0)
      $display("[TB] FAIL rmw_c0_we got %b%b want 00", dev0_we, dev1_we);
    else passed++;
    next_cycle();
    dev1_rd = 32'hffff_ffff;
    #1;
    checks++;
    if (dev1_we !== 1'b1 || dev0_we !== 1'b0)
      $display("[TB] FAIL rmw_c1_we got %b%b want 01", dev0_we, dev1_we);
    else passed++;
    checks++;
    if (t_wd !== 32'h1234_ab78) $display("[TB] FAIL rmw_c1_wd got %h want 1234ab78", t_wd);
    else passed++;
    checks++;
    if (t_addr !== 32'h7f38) $display("[TB] FAIL rmw_c1_addr got %h want 00007f38", t_addr);
    else passed++;
    checks++;
    if (stall !== 1'b0) $display("[TB] FAIL rmw_c1_stall got %b want 0", stall);
    else passed++;
    next_cycle();
    idle_inputs();
    dev1_rd = 32'h0;
    #1;
    checks++;
    if (dev1_we !== 1'b0 || stall !== 1'b0)
      $display("[TB] FAIL rmw_after got we %b stall %b want 0 0", dev1_we, stall);
    else passed++;
    next_cycle();
  endtask

  task automatic test_load();
    cpu_addr = 32'h7f3c;
    cpu_re   = 1'b1;
    dev1_rd  = 32'h0000_0005;
    #1;
    checks++;
    if (stall !== 1'b1) $display("[TB] FAIL load_c0_stall got %b want 1", stall);
    else passed++;
    checks++;
    if (cpu_rd !== 32'h0) $display("[TB] FAIL load_c0_rd got %h want 0", cpu_rd);
    else passed++;
    next_cycle();
    dev1_rd = 32'h0000_0009;
    #1;
    checks++;
    if (cpu_rd !== 32'h5) $display("[TB] FAIL load_c1_rd got %h want 00000005", cpu_rd);
    else passed++;
    checks++;
    if (stall !== 1'b0) $display("[TB] FAIL load_c1_stall got %b want 0", stall);
    else passed++;
    next_cycle();
    idle_inputs();
    #1;
    checks++;
    if (cpu_rd !== 32'h0) $display("[TB] FAIL load_after_rd got %h want 0", cpu_rd);
    else passed++;
    dev1_rd = 32'h0;
    next_cycle();
  endtask

  task automatic test_miss();
    int s0, s1;
    s0 = dev0_strobes;
    s1 = dev1_strobes;
    cpu_addr = 32'h8000;
    cpu_wd   = 32'hdead_beef;
    cpu_be   = 4'hf;
    cpu_we   = 1'b1;
    #1;
    checks++;
    if (dev0_we !== 1'b0 || dev1_we !== 1'b0 || stall !== 1'b0)
      $display("[TB] FAIL miss_store got we %b%b stall %b want 00 0", dev0_we, dev1_we, stall);
    else passed++;
    next_cycle();
    cpu_we = 1'b0;
    cpu_re = 1'b1;
    dev0_rd = 32'h1111_1111;
    dev1_rd = 32'h2222_2222;
    #1;
    checks++;
    if (stall !== 1'b0 || cpu_rd !== 32'h0)
      $display("[TB] FAIL miss_load got stall %b rd %h want 0 0", stall, cpu_rd);
    else passed++;
    next_cycle();
    checks++;
    if (cpu_rd !== 32'h0 || stall !== 1'b0)
      $display("[TB] FAIL miss_load_next got stall %b rd %h want 0 0", stall, cpu_rd);
    else passed++;
    checks++;
    if (dev0_strobes != s0 || dev1_strobes != s1)
      $display("[TB] FAIL miss_count got %0d/%0d want %0d/%0d", dev0_strobes, dev1_strobes, s0, s1);
    else passed++;
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_window_edge();
    cpu_addr = 32'h7f0b;
    cpu_re   = 1'b1;
    dev0_rd  = 32'haabb_ccdd;
    #1;
    checks++;
    if (stall !== 1'b1) $display("[TB] FAIL edge_hit_stall got %b want 1", stall);
    else passed++;
    next_cycle();
    checks++;
    if (cpu_rd !== 32'haabb_ccdd || stall !== 1'b0)
      $display("[TB] FAIL edge_hit_rd got rd %h stall %b want aabbccdd 0", cpu_rd, stall);
    else passed++;
    cpu_addr = 32'h7f0c;
    next_cycle();
    checks++;
    if (stall !== 1'b0) $display("[TB] FAIL edge_miss_stall got %b want 0", stall);
    else passed++;
    next_cycle();
    checks++;
    if (cpu_rd !== 32'h0) $display("[TB] FAIL edge_miss_rd got %h want 0", cpu_rd);
    else passed++;
    idle_inputs();
    dev0_rd = 32'h0;
    next_cycle();
  endtask

  task automatic test_reset_mid_rmw();
    int s0;
    cpu_addr = 32'h7f00;
    cpu_wd   = 32'h0000_beef;
    cpu_be   = 4'b0011;
    cpu_we   = 1'b1;
    dev0_rd  = 32'h1122_3344;
    #1;
    checks++;
    if (stall !== 1'b1) $display("[TB] FAIL mid_c0_stall got %b want 1", stall);
    else passed++;
    next_cycle();
    checks++;
    if (dev0_we !== 1'b1 || t_wd !== 32'h1122_beef)
      $display("[TB] FAIL mid_commit got we %b wd %h want 1 1122beef", dev0_we, t_wd);
    else passed++;
    s0 = dev0_strobes;
    clr = 1'b1;
    #1;
    checks++;
    if (dev0_we !== 1'b0 || stall !== 1'b0 || t_wd !== 32'h0 || t_addr !== 32'h0)
      $display("[TB] FAIL mid_clr got we %b stall %b wd %h addr %h want 0 0 0 0",
               dev0_we, stall, t_wd, t_addr);
    else passed++;
    next_cycle();
    checks++;
    if (dev0_strobes != s0) $display("[TB] FAIL mid_no_land got %0d want %0d", dev0_strobes, s0);
    else passed++;
    clr = 1'b0;
    idle_inputs();
    dev0_rd = 32'h0;
    next_cycle();
    cpu_addr = 32'h7f04;
    cpu_wd   = 32'h0000_0055;
    cpu_be   = 4'hf;
    cpu_we   = 1'b1;
    #1;
    checks++;
    if (dev0_we !== 1'b1 || dev1_we !== 1'b0 || stall !== 1'b0)
      $display("[TB] FAIL post_full_we got we %b%b stall %b want 10 0", dev0_we, dev1_we, stall);
    else passed++;
    checks++;
    if (t_addr !== 32'h7f04 || t_wd !== 32'h55)
      $display("[TB] FAIL post_full_bus got addr %h wd %h want 00007f04 00000055", t_addr, t_wd);
    else passed++;
    next_cycle();
    idle_inputs();
    #1;
    checks++;
    if (dev0_strobes != s0 + 1)
      $display("[TB] FAIL post_full_count got %0d want %0d", dev0_strobes, s0 + 1);
    else passed++;
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_full_store();
    test_byte_rmw();
    test_load();
    test_miss();
    test_window_edge();
    test_reset_mid_rmw();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/periph_bridge.md
# periph_bridge

Memory-mapped I/O bridge between the CPU data-memory stage and the peripherals, including the digital-tube display at 0x7f38–0x7f3f. It decodes CPU accesses into two peripheral windows and drives a shared peripheral bus (`t_addr`, `t_wd`, per-device write enable). Full-word stores pass through with no delay. Partial stores (sb/sh) become a two-cycle read-modify-write, and loads return registered data after a one-cycle stall.

## Interface
Parameters:
- `DEV0_BASE`, default 32'h7f00: first byte address of device 0 (timer) window
- `DEV0_TOP`, default 32'h7f0b: last byte address of device 0 window, inclusive
- `DEV1_BASE`, default 32'h7f38: first byte address of device 1 (digital tube) window
- `DEV1_TOP`, default 32'h7f3f: last byte address of device 1 window, inclusive

Ports:
- `clk`  in  1: the single clock
- `clr`  in  1: asynchronous, active-high reset
- `cpu_addr`  in  32: CPU byte address
- `cpu_wd`  in  32: CPU store data, already lane-aligned
- `cpu_be`  in  4: byte enables; bit i selects bits [8i+7:8i]
- `cpu_we`  in  1: store request
- `cpu_re`  in  1: load request
- `cpu_rd`  out  32: load data
- `stall`  out  1: freeze CPU pipeline; request inputs are held stable while high
- `t_addr`  out  32: peripheral word address, bits [1:0] = 0
- `t_wd`  out  32: peripheral write data
- `dev0_we`, `dev1_we`  out  1 each: per-device write strobe
- `dev0_rd`, `dev1_rd`  in  32 each: combinational read data from each device at `t_addr`

## Operation
- **Hit decode:** `hit0 = DEV0_BASE <= cpu_addr <= DEV0_TOP`, and likewise `hit1` for device 1. `hit = hit0 | hit1`. `dev_rd` is the read data of the hit device.
- **States:** IDLE, RD_DONE, WR_COMMIT. Reset state is IDLE.
- **IDLE, `cpu_we & hit & cpu_be == 4'hf`:**
  - Pass-through write: `t_addr = {cpu_addr[31:2], 2'b00}`, `t_wd = cpu_wd`, matching `devN_we = 1`.
  - `stall = 0`; state stays IDLE.
- **IDLE, `cpu_we & hit`, `cpu_be` not 0 and not 4'hf:**
  - `stall = 1`.
  - Latch address, device select, and `merge = (dev_rd & ~M) | (cpu_wd & M)`, where M is `cpu_be` expanded to a byte mask.
  - Go to WR_COMMIT.
- **WR_COMMIT:**
  - `t_addr` = latched address, `t_wd = merge`, latched `devN_we = 1`, `stall = 0`.
  - Go to IDLE.
- **IDLE, `cpu_re & hit & ~cpu_we`:**
  - `stall = 1`; `rd_buf <= dev_rd`.
  - Go to RD_DONE.
- **RD_DONE:** `cpu_rd = rd_buf`, `stall = 0`; go to IDLE.
- **Miss** (no hit): no write strobe and no stall. `cpu_rd = 0`.
- **Ignored requests:**
  - `cpu_we` with `cpu_be == 0` is ignored.
  - When `cpu_we` and `cpu_re` are both high, the write is processed and the read is ignored.
- **`cpu_rd`** is 0 in every state other than RD_DONE.
- **Reset:** `clr` asserted in any state, including mid-RMW, goes immediately to IDLE and clears `rd_buf`, `merge` and the latched address. A pending partial write is dropped; no strobe is issued.

## Timing
- **Outputs while `clr` is high:** `stall = 0`, `dev0_we = dev1_we = 0`, `cpu_rd = 0`, `t_wd = 0`, `t_addr = 0`.
- **Full-word store:** 0 cycles of stall; the strobe is in the request cycle and the device captures at the next edge.
- **Partial store:**
  - Cycle 0: `stall = 1`, no strobe.
  - Cycle 1: strobe with merged data and `stall = 0`.
  - The CPU retires the store at the end of cycle 1.
- **Load:** `stall = 1` in cycle 0; data is valid on `cpu_rd` in cycle 1 with `stall = 0`.
- **Request encoding in RD_DONE and WR_COMMIT:** the CPU still presents the same request in these states; the FSM ignores request inputs there. No request is re-triggered.
- **Write strobes:** at most one `devN_we` is high in any cycle; both devices never strobe together.

## Structure
- Shared package `mmio_pkg`:
  - state encoding (IDLE = 2'd0, RD_DONE = 2'd1, WR_COMMIT = 2'd2)
  - default window constants (7f00/7f0b/7f38/7f3f)
  - the miss read value (32'h0)
- One sub-module, `be_merge`: combinational byte-mask merge of old data, new data and `be`. It is reused by the data-memory path.

## Test plan
- **Full-word store:** store 0x12345678 to 0x7f38, be = f → `dev1_we = 1` in the same cycle, `t_addr = 0x7f38`, `t_wd = 0x12345678`, `stall = 0`.
- **Byte store (RMW):** store byte at 0x7f39, be = 4'b0010, wd = 0x0000AB00, with `dev1_rd = 0x12345678` → cycle 0 `stall = 1`, no strobe; cycle 1 `dev1_we = 1`, `t_wd = 0x1234AB78`, `t_addr = 0x7f38`.
- **Load from device 1:** load 0x7f3c with `dev1_rd = 0x00000005` → `stall = 1` for one cycle, then `cpu_rd = 5`, `stall = 0`; `cpu_rd = 0` afterwards.
- **Miss:** store 0xdeadbeef to 0x8000 → no strobe, no stall; load from 0x8000 → `cpu_rd = 0`, no stall.
- **Window edge:** load 0x7f0b (hit on device 0, one stall) versus 0x7f0c (miss, no stall).
- **Reset mid-RMW:** assert `clr` during WR_COMMIT of a halfword store to 0x7f00 → `dev0_we` drops immediately, state is IDLE, no write lands; a full-word store after release works normally.
